shift_execute: RTL
==================

Name: shift_execute

Overview:
- Execute-side consumer of the shift issue → execute interface in the CrackCore backend.
- Accepts one decoded shift op (function select, renamed rd, op1, op2, is32) per cycle under a valid/ready handshake.
- Computes the RV64I shift result in a two-stage pipeline and presents it to the writeback path under a second valid/ready handshake.
- A synchronous flush discards all in-flight ops on mispredict or exception.

Parameters:
- DW, 64, datapath width; fixed at 64 for RV64I.
- RNBIT, 2, rename-copy index bits; rd index width is 5+RNBIT.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline kill.
- shift_execute_vaild  input  1  issue presents an op.
- shift_execute_ready  output  1  this block accepts the op this cycle.
- shift_execute_info  input  139  {fun_sll, fun_srl, fun_sra, rd0_index[5+RNBIT-1:0], op1[63:0], op2[63:0], is32}, MSB first.
- shift_writeback_vaild  output  1  result available.
- shift_writeback_ready  input  1  writeback accepts the result.
- shift_writeback_rd0  output  5+RNBIT  {arch reg[4:0], rename copy[RNBIT-1:0]}.
- shift_writeback_data  output  64  result.

Behaviour:
- Reset: both stage valid bits are 0. shift_writeback_vaild=0, shift_writeback_rd0=0, shift_writeback_data=0. shift_execute_ready is 1 in the first cycle after RST deasserts.
- Stage E1 (operand register): captures info on accept, where accept = shift_execute_vaild & shift_execute_ready.
- Stage E2 (result register): holds the computed result, rd0 and a valid bit. Drives the writeback ports directly from registers; no combinational path from the info input to the writeback outputs.
- Advance rules:
  - e2_free = ~e2_valid | shift_writeback_ready.
  - e1_move = e1_valid & e2_free.
  - shift_execute_ready = ~e1_valid | e1_move. This is combinational from shift_writeback_ready only, never from shift_execute_vaild.
- Latency and throughput: an op accepted in cycle N reaches writeback valid at edge N+2. Sustained throughput is 1 op/cycle while shift_writeback_ready=1.
- Backpressure: when ready is low with E2 valid, E2 holds its rd0/data stable. Once E1 is also full, shift_execute_ready=0. No op is lost or duplicated.
- Simultaneous E2 drain and E1 move in one cycle: E2 reloads from E1 in the same edge.
- Shift amount: is32 ? op2[4:0] : op2[5:0]. Upper op2 bits are ignored.
- 64-bit results (is32=0):
  - sll: op1 << sh.
  - srl: op1 >> sh, logical.
  - sra: $signed(op1) >>> sh.
- 32-bit results (is32=1): shift op1[31:0] as a 32-bit value (srl zero-fills, sra sign-fills from bit 31), then sign-extend bit 31 to 64.
- Function select must be one-hot. If zero or more than one of fun_sll/srl/sra is set, data=0 and the op still writes back to rd0.
- rd0 arch reg == 0 (x0): writeback still occurs, with data forced to 0.
- flush:
  - Clears e1_valid and e2_valid at the edge.
  - shift_execute_ready is forced 0 during the flush cycle, so no op is accepted that cycle.
  - Flush overrides any simultaneous accept or advance.
  - shift_writeback_vaild=0 from the next cycle; data and rd0 are don't-care once valid is 0.
- RST mid-operation: same as flush, and the data/rd0 registers also return to 0.

Test Plan:
- Reset then single op: sll, is32=0, op1=0x1, op2=0x41, rd0=0x0C. Required: vaild=1 exactly 2 cycles after accept, data=0x2 (only 6 shamt bits used), rd0=0x0C.
- sraw: op1=0x0000_0000_8000_0000, op2=4, is32=1. Required: data=0xFFFF_FFFF_F800_0000. srlw with the same operands: data=0x0000_0000_0800_0000. sllw with op1=0x8000_0001, op2=1: data=0x2.
- 64-bit srl vs sra: op1=0xF000_0000_0000_0000, shamt=60. Required: srl=0xF, sra=0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: 4 back-to-back ops with shift_writeback_ready held 0 for 5 cycles. Required: ready drops after 2 accepts, E2 output stays stable, then all 4 results emerge in order, one per cycle after release.
- Flush with E1 and E2 full and a new op presented. Required: that op is not accepted, vaild=0 next cycle, no stale result later, and the next accepted op is written back normally.
- rd0 arch=0 with sra of 0xFF: data=0. Non-one-hot fun (sll|srl): data=0, rd0 preserved.

Source files
------------

// File: rtl/shift_execute.sv
// RV64I shift execute unit: two-stage (operand register, result register) pipeline
// between the shift issue handshake and the writeback handshake, with synchronous flush.
module shift_execute #(
    parameter  int DW    = 64,
    parameter  int RNBIT = 2,
    localparam int RDW   = 5 + RNBIT,
    localparam int IW    = 3 + RDW + 2 * DW + 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           flush,
    input  logic           shift_execute_vaild,
    output logic           shift_execute_ready,
    input  logic [IW-1:0]  shift_execute_info,
    output logic           shift_writeback_vaild,
    input  logic           shift_writeback_ready,
    output logic [RDW-1:0] shift_writeback_rd0,
    output logic [DW-1:0]  shift_writeback_data
);

    typedef struct packed {
        logic [2:0]     fun;   // {sll, srl, sra}
        logic [RDW-1:0] rd;
        logic [DW-1:0]  op1;
        logic [DW-1:0]  op2;
        logic           is32;
    } op_t;

    op_t            in_op;
    op_t            e1_op;
    logic           e1_valid;
    logic           e2_valid;
    logic [RDW-1:0] e2_rd;
    logic [DW-1:0]  e2_data;

    logic           e2_free;
    logic           e1_move;
    logic           accept;
    logic [5:0]     sh;
    logic [DW-1:0]  r64;
    logic [31:0]    r32;
    logic           one_hot;
    logic [DW-1:0]  result;

    assign in_op = shift_execute_info;

    assign e2_free             = ~e2_valid | shift_writeback_ready;
    assign e1_move             = e1_valid & e2_free;
    assign shift_execute_ready = ~flush & (~e1_valid | e1_move);
    assign accept              = shift_execute_vaild & shift_execute_ready;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        sh      = e1_op.is32 ? {1'b0, e1_op.op2[4:0]} : e1_op.op2[5:0];
        r64     = '0;
        r32     = '0;
        one_hot = 1'b1;
        case (e1_op.fun)
            3'b100: begin
                r64 = e1_op.op1 << sh;
                r32 = e1_op.op1[31:0] << sh[4:0];
            end
            3'b010: begin
                r64 = e1_op.op1 >> sh;
                r32 = e1_op.op1[31:0] >> sh[4:0];
            end
            3'b001: begin
                r64 = $signed(e1_op.op1) >>> sh;
                r32 = $signed(e1_op.op1[31:0]) >>> sh[4:0];
            end
            default: one_hot = 1'b0;
        endcase
        // Illegal function encodings and writes to x0 still retire, carrying zero.
        if (!one_hot || e1_op.rd[RDW-1:RNBIT] == '0)
            result = '0;
        else if (e1_op.is32)
            result = {{(DW-32){r32[31]}}, r32};
        else
            result = r64;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            e1_valid <= 1'b0;
            e2_valid <= 1'b0;
        end else begin
            if (accept)
                e1_valid <= 1'b1;
            else if (e1_move)
                e1_valid <= 1'b0;

            if (e1_move)
                e2_valid <= 1'b1;
            else if (shift_writeback_ready)
                e2_valid <= 1'b0;
        end
    end

    // NOTE: the operand payload is not reset; it is qualified by e1_valid everywhere.
    always_ff @(posedge CLK) begin
        if (accept)
            e1_op <= in_op;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            e2_rd   <= '0;
            e2_data <= '0;
        end else if (e1_move && !flush) begin
            e2_rd   <= e1_op.rd;
            e2_data <= result;
        end
    end

    assign shift_writeback_vaild = e2_valid;
    assign shift_writeback_rd0   = e2_rd;
    assign shift_writeback_data  = e2_data;

endmodule
